// File: rtl/trig_pkg.sv
// Shared types and helpers for the Ctrl4 trigger scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trig_pkg;

    localparam int NCH = 4;
    localparam int PW  = $clog2(NCH);

    localparam logic [NCH-1:0] CHSEL_RST = 4'b0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DLY   = 2'd1,
        PULSE = 2'd2
    } state_t;

    // First set bit of mask found scanning upward from the one-hot ptr, wrapping
    // from the top channel back to the bottom. Returns zero for an empty mask.
    function automatic logic [NCH-1:0] next_enabled(
        input logic [NCH-1:0] ptr,
        input logic [NCH-1:0] mask
    );
        logic [NCH-1:0] res;
        logic [PW-1:0]  p;
        logic [PW-1:0]  idx;
        logic           found;
        res   = '0;
        p     = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (ptr[i]) p = PW'(i);
        end
        for (int k = 0; k < NCH; k++) begin
            idx = p + PW'(k);
            if (!found && mask[idx]) begin
                res[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [NCH-1:0] rotl1(input logic [NCH-1:0] v);
        return {v[NCH-2:0], v[NCH-1]};
    endfunction

endpackage

// File: rtl/trig_sync_edge.sv
// Synchronises an asynchronous trigger and flags each rising edge for one cycle.
// Latency: rise asserted SYNC_STAGES cycles after the input is first sampled high.
// Backpressure: none; one rise pulse per input rising edge regardless of high time.
module trig_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/trig_seq_ctrl.sv
// Trigger scheduler: delays each accepted TRIGIN rise and drives a WIDTH-cycle pulse on one/all channels.
// Latency: trigout first high DELAY+1 cycles after the synchronised rise is detected.
// Backpressure: rises arriving while busy are dropped and counted in miss_cnt (saturating).
module trig_seq_ctrl
    import trig_pkg::*;
#(
    parameter int DW          = 16,
    parameter int MW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          trigin,
    input  logic          arm,
    input  logic          mode,
    input  logic [NCH:1]  ch_en,
    input  logic [DW-1:0] delay,
    input  logic [DW-1:0] width,
    input  logic          clr_miss,
    output logic [NCH:1]  trigout,
    output logic [NCH:1]  chsel,
    output logic          busy,
    output logic [MW-1:0] miss_cnt,
    output logic          ledout
);

    logic           rise;
    state_t         state_q, state_d;
    logic [DW-1:0]  dcnt_q, wcnt_q;
    logic [DW-1:0]  width_eff;
    logic [NCH-1:0] en;
    logic [NCH-1:0] tgt_q, new_tgt;
    logic [NCH-1:0] chsel_q;
    logic [NCH-1:0] trigout_q, trigout_d;
    logic [MW-1:0]  miss_q;
    logic           accept, miss_inc;

    trig_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (trigin),
        .rise  (rise)
    );

    assign en        = ch_en;
    assign width_eff = (width == '0) ? DW'(1) : width;
    assign new_tgt   = mode ? en : next_enabled(chsel_q, en);
    assign accept    = rise && (state_q == IDLE) && arm && (en != '0);
    assign miss_inc  = rise && (state_q != IDLE) && arm && (en != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A zero delay skips DLY so the pulse still starts the cycle after detection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (delay == '0) ? PULSE : DLY;
            DLY:     if (dcnt_q <= DW'(1)) state_d = PULSE;
            PULSE:   if (wcnt_q <= DW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        trigout_d = '0;
        if (state_d == PULSE) begin
            trigout_d = accept ? new_tgt : tgt_q;
        end
    end

    // Delay, width and target are captured at acceptance so later input changes
    // cannot disturb a trigger already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q    <= '0;
            wcnt_q    <= '0;
            tgt_q     <= '0;
            chsel_q   <= CHSEL_RST;
            trigout_q <= '0;
            miss_q    <= '0;
        end else begin
            trigout_q <= trigout_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        dcnt_q <= delay;
                        wcnt_q <= width_eff;
                        tgt_q  <= new_tgt;
                    end
                end
                DLY:     dcnt_q <= dcnt_q - 1'b1;
                PULSE:   wcnt_q <= wcnt_q - 1'b1;
                default: ;
            endcase
            if (accept && !mode) begin
                chsel_q <= rotl1(new_tgt);
            end
            if (clr_miss) begin
                miss_q <= '0;
            end else if (miss_inc && (miss_q != '1)) begin
                miss_q <= miss_q + 1'b1;
            end
        end
    end

    assign trigout  = trigout_q;
    assign chsel    = chsel_q;
    assign busy     = (state_q != IDLE);
    assign miss_cnt = miss_q;
    assign ledout   = ~|trigout_q;

endmodule

// File: tb/tb_trig_seq_ctrl.sv
// Directed bench for trig_seq_ctrl: table of single-trigger vectors plus miss/reset sequences.
module tb_trig_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        trigin;
    logic        arm;
    logic        mode;
    logic [4:1]  ch_en;
    logic [15:0] delay;
    logic [15:0] width;
    logic        clr_miss;
    logic [4:1]  trigout;
    logic [4:1]  chsel;
    logic        busy;
    logic [7:0]  miss_cnt;
    logic        ledout;

    int n_cmp = 0;
    int n_err = 0;
    int wait_n;
    int len;

    typedef struct {
        logic        arm;
        logic        mode;
        logic [3:0]  ch_en;
        logic [15:0] delay;
        logic [15:0] width;
        logic        chg;
        int          e_first;
        int          e_len;
        logic [3:0]  e_mask;
        int          e_busy;
        logic [3:0]  e_chsel;
    } vec_t;

    vec_t vt[14];

    trig_seq_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .trigin   (trigin),
        .arm      (arm),
        .mode     (mode),
        .ch_en    (ch_en),
        .delay    (delay),
        .width    (width),
        .clr_miss (clr_miss),
        .trigout  (trigout),
        .chsel    (chsel),
        .busy     (busy),
        .miss_cnt (miss_cnt),
        .ledout   (ledout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycle 0 starts just after a rising edge; the rise is detected in cycle 2.
    task automatic run_vec(input vec_t v, input int idx);
        int         first, plen, blen, ledlow;
        logic [3:0] orm;
        first = -1; plen = 0; blen = 0; ledlow = 0; orm = '0;
        arm = v.arm; mode = v.mode; ch_en = v.ch_en; delay = v.delay; width = v.width;
        for (int c = 0; c < 20; c++) begin
            if (c == 0) trigin = 1'b1;
            @(negedge clk);
            if (trigout != 4'b0000) begin
                if (first < 0) first = c;
                plen++;
                orm = orm | trigout;
            end
            if (busy) blen++;
            if (!ledout) ledlow++;
            if (c == 3) begin
                trigin = 1'b0;
                if (v.chg) begin
                    ch_en = ~ch_en; mode = ~mode; delay = 16'd7; width = 16'd9;
                end
            end
            @(posedge clk);
            #1;
        end
        check($sformatf("v%0d first", idx), first, v.e_first);
        check($sformatf("v%0d len", idx), plen, v.e_len);
        check($sformatf("v%0d mask", idx), int'(orm), int'(v.e_mask));
        check($sformatf("v%0d busy", idx), blen, v.e_busy);
        check($sformatf("v%0d led", idx), ledlow, v.e_len);
        check($sformatf("v%0d chsel", idx), int'(chsel), int'(v.e_chsel));
        check($sformatf("v%0d miss", idx), int'(miss_cnt), 0);
    endtask

    initial begin
        //            arm  mode ch_en    dly    wid    chg first len mask     busy chsel
        vt[0]  = '{1'b1, 1'b0, 4'b1111, 16'd0, 16'd2, 1'b0, 3,  2, 4'b0001, 2, 4'b0010};
        vt[1]  = '{1'b1, 1'b0, 4'b1111, 16'd0, 16'd2, 1'b0, 3,  2, 4'b0010, 2, 4'b0100};
        vt[2]  = '{1'b1, 1'b0, 4'b1111, 16'd0, 16'd2, 1'b0, 3,  2, 4'b0100, 2, 4'b1000};
        vt[3]  = '{1'b1, 1'b0, 4'b1111, 16'd0, 16'd2, 1'b0, 3,  2, 4'b1000, 2, 4'b0001};
        vt[4]  = '{1'b1, 1'b0, 4'b1111, 16'd0, 16'd2, 1'b0, 3,  2, 4'b0001, 2, 4'b0010};
        vt[5]  = '{1'b1, 1'b0, 4'b1010, 16'd0, 16'd2, 1'b0, 3,  2, 4'b0010, 2, 4'b0100};
        vt[6]  = '{1'b1, 1'b0, 4'b1010, 16'd0, 16'd2, 1'b0, 3,  2, 4'b1000, 2, 4'b0001};
        vt[7]  = '{1'b1, 1'b0, 4'b1010, 16'd0, 16'd2, 1'b0, 3,  2, 4'b0010, 2, 4'b0100};
        vt[8]  = '{1'b1, 1'b0, 4'b1111, 16'd5, 16'd3, 1'b0, 8,  3, 4'b0100, 8, 4'b1000};
        vt[9]  = '{1'b1, 1'b0, 4'b1111, 16'd0, 16'd0, 1'b0, 3,  1, 4'b1000, 1, 4'b0001};
        vt[10] = '{1'b1, 1'b1, 4'b0111, 16'd2, 16'd4, 1'b0, 5,  4, 4'b0111, 6, 4'b0001};
        vt[11] = '{1'b1, 1'b1, 4'b0111, 16'd2, 16'd4, 1'b1, 5,  4, 4'b0111, 6, 4'b0001};
        vt[12] = '{1'b0, 1'b0, 4'b1111, 16'd0, 16'd2, 1'b0, -1, 0, 4'b0000, 0, 4'b0001};
        vt[13] = '{1'b1, 1'b0, 4'b0000, 16'd0, 16'd2, 1'b0, -1, 0, 4'b0000, 0, 4'b0001};

        rst_n = 1'b0; trigin = 1'b0; arm = 1'b0; mode = 1'b0; ch_en = '0;
        delay = '0; width = '0; clr_miss = 1'b0;
        #12;
        check("rst trigout", int'(trigout), 0);
        check("rst chsel", int'(chsel), 1);
        check("rst busy", int'(busy), 0);
        check("rst miss", int'(miss_cnt), 0);
        check("rst ledout", int'(ledout), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(3);

        for (int i = 0; i < 14; i++) run_vec(vt[i], i);

        // Second rise lands mid-pulse: dropped and counted once.
        arm = 1'b1; mode = 1'b0; ch_en = 4'b1111; delay = 16'd0; width = 16'd10;
        len = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 0 || c == 6) trigin = 1'b1;
            if (c == 2 || c == 8) trigin = 1'b0;
            @(negedge clk);
            if (trigout != 4'b0000) len++;
            @(posedge clk);
            #1;
        end
        check("miss1 len", len, 10);
        check("miss1 cnt", int'(miss_cnt), 1);

        // 300 rises under one long pulse: first accepted, the rest saturate the counter.
        width = 16'd2000;
        for (int i = 0; i < 300; i++) begin
            trigin = 1'b1; tick(1);
            trigin = 1'b0; tick(1);
        end
        check("miss sat", int'(miss_cnt), 255);
        wait_n = 0;
        while (busy && wait_n < 3000) begin
            tick(1);
            wait_n++;
        end
        check("drain1 busy", int'(busy), 0);

        // Clear coincides with a missed rise: clear wins.
        width = 16'd50;
        for (int c = 0; c < 20; c++) begin
            if (c == 0 || c == 10) trigin = 1'b1;
            if (c == 3) trigin = 1'b0;
            if (c == 12) clr_miss = 1'b1;
            if (c == 13) begin clr_miss = 1'b0; trigin = 1'b0; end
            tick(1);
        end
        check("clr prio", int'(miss_cnt), 0);
        wait_n = 0;
        while (busy && wait_n < 200) begin
            tick(1);
            wait_n++;
        end
        check("drain2 busy", int'(busy), 0);

        // Async reset mid-pulse.
        ch_en = 4'b0100; width = 16'd10;
        trigin = 1'b1; tick(2);
        trigin = 1'b0; tick(4);
        check("pre-rst trigout", int'(trigout), 4);
        check("pre-rst chsel", int'(chsel), 8);
        #1 rst_n = 1'b0;
        #1;
        check("arst trigout", int'(trigout), 0);
        check("arst ledout", int'(ledout), 1);
        check("arst busy", int'(busy), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("post-rst chsel", int'(chsel), 1);
        check("post-rst trigout", int'(trigout), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
